sram_boot_loader: RTL

- Sits directly upstream of the dual-port main SRAM, on its instruction-bus port; owns that port during boot.
- After reset, copies BOOT_WORDS 32-bit words from a synchronous boot ROM into SRAM starting at word address SRAM_BASE, holding the CPU in reset meanwhile.
- When the copy completes, releases CPU reset and becomes a transparent pass-through from the CPU instruction bus to the SRAM instruction port.

---
 rtl/sram_boot_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sram_boot_loader.sv
// Boot loader: copies BOOT_WORDS from boot ROM into SRAM, then passes CPU fetches straight through.
// Latency: 4 cycles/word copy (8 with BOOT_VERIFY_EN read-back check); pass-through is combinational.
// Backpressure: each copy word waits on sram_i_ready indefinitely; CPU requests are dropped until boot_done.
module sram_boot_loader #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 15,
    parameter int ROM_ADDR_W  = 10,
    parameter int BOOT_WORDS  = 1024,
    parameter int SRAM_BASE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_en,
    output logic [ROM_ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]        rom_rdata,
    input  logic                     cpu_i_valid,
    input  logic [SRAM_ADDR_W-3:0]   cpu_i_addr,
    output logic [DATA_W-1:0]        cpu_i_rdata,
    output logic                     cpu_i_ready,
    output logic                     sram_i_valid,
    output logic [SRAM_ADDR_W-3:0]   sram_i_addr,
    output logic [DATA_W-1:0]        sram_i_wdata,
    output logic [DATA_W/8-1:0]      sram_i_wstrb,
    input  logic [DATA_W-1:0]        sram_i_rdata,
    input  logic                     sram_i_ready,
    input  logic                     boot_restart,
    output logic                     cpu_rst,
`ifdef BOOT_VERIFY_EN
    output logic                     boot_err,
`endif
    output logic                     boot_done
);

    localparam int WA_W = SRAM_ADDR_W - 2;

    typedef enum logic [3:0] {
        ST_RD,
        ST_LATCH,
        ST_WR,
        ST_WAIT,
`ifdef BOOT_VERIFY_EN
        ST_RD2,
        ST_LATCH2,
        ST_VRD,
        ST_VWAIT,
`endif
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ROM_ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]       wbuf_q, wbuf_d;
    logic                    cpu_rst_q;
    logic                    boot_done_q;
    logic [WA_W-1:0]         boot_addr;
    logic                    last_word;
`ifdef BOOT_VERIFY_EN
    logic                    boot_err_q, boot_err_d;
`endif

    // Copy destination wraps modulo the SRAM word space.
    assign boot_addr = WA_W'(SRAM_BASE) + WA_W'(cnt_q);
    assign last_word = (cnt_q == ROM_ADDR_W'(BOOT_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RD;
            cnt_q       <= '0;
            wbuf_q      <= '0;
            cpu_rst_q   <= 1'b1;
            boot_done_q <= 1'b0;
`ifdef BOOT_VERIFY_EN
            boot_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wbuf_q      <= wbuf_d;
            cpu_rst_q   <= (state_d != ST_DONE);
            boot_done_q <= (state_d == ST_DONE);
`ifdef BOOT_VERIFY_EN
            boot_err_q  <= boot_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wbuf_d       = wbuf_q;
        rom_en       = 1'b0;
        rom_addr     = cnt_q;
        sram_i_valid = 1'b0;
        sram_i_addr  = boot_addr;
        sram_i_wdata = '0;
        sram_i_wstrb = '0;
        cpu_i_rdata  = '0;
        cpu_i_ready  = 1'b0;
`ifdef BOOT_VERIFY_EN
        boot_err_d   = boot_err_q;
`endif
        case (state_q)
            ST_RD: begin
                // Reset parks the FSM here; keep the ROM quiet until reset drops.
                rom_en  = ~rst;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                wbuf_d  = rom_rdata;
                state_d = ST_WR;
            end
            ST_WR: begin
                sram_i_valid = 1'b1;
                sram_i_wdata = wbuf_q;
                sram_i_wstrb = '1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (sram_i_ready) begin
                    if (last_word) begin
`ifdef BOOT_VERIFY_EN
                        cnt_d   = '0;
                        state_d = ST_RD2;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
`ifdef BOOT_VERIFY_EN
            ST_RD2: begin
                rom_en  = ~rst;
                state_d = ST_LATCH2;
            end
            ST_LATCH2: begin
                wbuf_d  = rom_rdata;
                state_d = ST_VRD;
            end
            ST_VRD: begin
                sram_i_valid = 1'b1;
                state_d      = ST_VWAIT;
            end
            ST_VWAIT: begin
                if (sram_i_ready) begin
                    if (sram_i_rdata != wbuf_q) begin
                        boot_err_d = 1'b1;
                    end
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_RD2;
                    end
                end
            end
`endif
            ST_DONE: begin
                sram_i_valid = cpu_i_valid;
                sram_i_addr  = cpu_i_addr;
                cpu_i_rdata  = sram_i_rdata;
                cpu_i_ready  = sram_i_ready;
                if (boot_restart) begin
                    cnt_d   = '0;
                    state_d = ST_RD;
`ifdef BOOT_VERIFY_EN
                    boot_err_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_RD;
            end
        endcase
    end

    assign cpu_rst   = cpu_rst_q;
    assign boot_done = boot_done_q;
`ifdef BOOT_VERIFY_EN
    assign boot_err  = boot_err_q;
`endif

endmodule
